// File: rtl/input_p4_demux_if.sv
// AXI4-Stream bundle shared by the ingress side and the five switch-facing
// sides of input_p4_demux.
interface input_p4_demux_if #(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 304
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/input_p4_demux.sv
// Steers whole packets from one AXI4-Stream to one of five virtual-switch
// inputs by 802.1Q VID; untagged goes to the default switch, bad VIDs drop.
module input_p4_demux #(
    parameter int          C_M_AXIS_DATA_WIDTH  = 256,
    parameter int          C_S_AXIS_DATA_WIDTH  = 256,
    parameter int          C_M_AXIS_TUSER_WIDTH = 304,
    parameter int          C_S_AXIS_TUSER_WIDTH = 304,
    parameter int          NUM_SWITCHES         = 5,
    parameter logic [11:0] VID_BASE             = 12'd1,
    parameter int          DEFAULT_SWITCH       = 0
) (
    input  logic             axis_aclk,
    input  logic             axis_reset,
    input_p4_demux_if.slave  s_axis,
    input_p4_demux_if.master m_axis_0,
    input_p4_demux_if.master m_axis_1,
    input_p4_demux_if.master m_axis_2,
    input_p4_demux_if.master m_axis_3,
    input_p4_demux_if.master m_axis_4,
    output logic             pkt_fwd,
    output logic             pkt_drop
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    localparam logic [15:0] ETH_VLAN = 16'h8100;

    state_e                             state_q, state_d;
    logic                               out_valid_q;
    logic [C_M_AXIS_DATA_WIDTH-1:0]     out_data_q;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0]   out_keep_q;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]    out_user_q;
    logic                               out_last_q;
    logic [2:0]                         out_dest_q;
    logic [2:0]                         pkt_dest_q, pkt_dest_d;
    logic                               pkt_fwd_q, pkt_fwd_d;
    logic                               pkt_drop_q, pkt_drop_d;
    logic                               load_s;
    logic [2:0]                         load_dest_s;
    logic                               dest_ready_s;
    logic                               slot_free_s;
    logic                               accept_s;
    logic [C_S_AXIS_DATA_WIDTH-1:0]     in_data_s;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]    in_user_s;
    logic [15:0]                        ethertype_s;
    logic [11:0]                        vid_s, vid_off_s;
    logic                               first_hit_s;
    logic [2:0]                         first_dest_s;

    assign in_data_s   = s_axis.tdata;
    assign in_user_s   = s_axis.tuser;
    assign ethertype_s = {in_data_s[103:96], in_data_s[111:104]};
    assign vid_s       = {in_data_s[115:112], in_data_s[127:120]};
    // 12-bit wrap makes VID < VID_BASE land far out of range.
    assign vid_off_s    = vid_s - VID_BASE;
    assign first_hit_s  = (ethertype_s != ETH_VLAN) || (vid_off_s < 12'(NUM_SWITCHES));
    assign first_dest_s = (ethertype_s != ETH_VLAN) ? 3'(DEFAULT_SWITCH) : vid_off_s[2:0];

    // Ready of whichever switch the slot is currently presenting to.
    always_comb begin
        dest_ready_s = 1'b0;
        case (out_dest_q)
            3'd0:    dest_ready_s = m_axis_0.tready;
            3'd1:    dest_ready_s = m_axis_1.tready;
            3'd2:    dest_ready_s = m_axis_2.tready;
            3'd3:    dest_ready_s = m_axis_3.tready;
            3'd4:    dest_ready_s = m_axis_4.tready;
            default: dest_ready_s = 1'b0;
        endcase
    end

    assign slot_free_s   = ~out_valid_q | dest_ready_s;
    assign s_axis.tready = (state_q == ST_DROP) ? 1'b1 : slot_free_s;
    assign accept_s      = s_axis.tvalid & s_axis.tready;

    // Packet-level FSM: decode on the first beat, then follow to tlast.
    always_comb begin
        state_d     = state_q;
        pkt_dest_d  = pkt_dest_q;
        load_s      = 1'b0;
        load_dest_s = pkt_dest_q;
        pkt_fwd_d   = 1'b0;
        pkt_drop_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (first_hit_s) begin
                        load_s      = 1'b1;
                        load_dest_s = first_dest_s;
                        pkt_dest_d  = first_dest_s;
                        pkt_fwd_d   = 1'b1;
                        state_d     = s_axis.tlast ? ST_IDLE : ST_FWD;
                    end else begin
                        pkt_drop_d = 1'b1;
                        state_d    = s_axis.tlast ? ST_IDLE : ST_DROP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FWD: begin
                if (accept_s) begin
                    load_s  = 1'b1;
                    state_d = s_axis.tlast ? ST_IDLE : ST_FWD;
                end else begin
                    state_d = ST_FWD;
                end
            end
            ST_DROP: begin
                if (accept_s && s_axis.tlast) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pulse and output-slot registers.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q     <= ST_IDLE;
            pkt_dest_q  <= 3'd0;
            pkt_fwd_q   <= 1'b0;
            pkt_drop_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_user_q  <= '0;
            out_last_q  <= 1'b0;
            out_dest_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            pkt_dest_q <= pkt_dest_d;
            pkt_fwd_q  <= pkt_fwd_d;
            pkt_drop_q <= pkt_drop_d;
            if (load_s) begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_data_s;
                out_keep_q  <= s_axis.tkeep;
                out_user_q  <= in_user_s;
                out_last_q  <= s_axis.tlast;
                out_dest_q  <= load_dest_s;
            end else if (dest_ready_s) begin
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= out_valid_q;
            end
        end
    end

    assign pkt_fwd  = pkt_fwd_q;
    assign pkt_drop = pkt_drop_q;

    // Payload fans out to every port; only the selected one sees tvalid.
    assign m_axis_0.tdata  = out_data_q;
    assign m_axis_0.tkeep  = out_keep_q;
    assign m_axis_0.tuser  = out_user_q;
    assign m_axis_0.tlast  = out_last_q;
    assign m_axis_0.tvalid = out_valid_q & (out_dest_q == 3'd0);
    assign m_axis_1.tdata  = out_data_q;
    assign m_axis_1.tkeep  = out_keep_q;
    assign m_axis_1.tuser  = out_user_q;
    assign m_axis_1.tlast  = out_last_q;
    assign m_axis_1.tvalid = out_valid_q & (out_dest_q == 3'd1);
    assign m_axis_2.tdata  = out_data_q;
    assign m_axis_2.tkeep  = out_keep_q;
    assign m_axis_2.tuser  = out_user_q;
    assign m_axis_2.tlast  = out_last_q;
    assign m_axis_2.tvalid = out_valid_q & (out_dest_q == 3'd2);
    assign m_axis_3.tdata  = out_data_q;
    assign m_axis_3.tkeep  = out_keep_q;
    assign m_axis_3.tuser  = out_user_q;
    assign m_axis_3.tlast  = out_last_q;
    assign m_axis_3.tvalid = out_valid_q & (out_dest_q == 3'd3);
    assign m_axis_4.tdata  = out_data_q;
    assign m_axis_4.tkeep  = out_keep_q;
    assign m_axis_4.tuser  = out_user_q;
    assign m_axis_4.tlast  = out_last_q;
    assign m_axis_4.tvalid = out_valid_q & (out_dest_q == 3'd4);
endmodule

// File: tb/tb_input_p4_demux.sv
// Randomized and directed bench for input_p4_demux against an ordered
// beat-queue model of the demultiplexer.
`timescale 1ns/1ps
module tb_input_p4_demux;
    localparam int DW = 256;
    localparam int UW = 304;
    localparam int KW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid, in_last;
    logic [DW-1:0] in_data;
    logic [KW-1:0] in_keep;
    logic [UW-1:0] in_user;
    logic [4:0]    rdy;
    logic [4:0]    o_valid, o_last;
    logic [DW-1:0] o_data [5];
    logic [KW-1:0] o_keep [5];
    logic [UW-1:0] o_user [5];
    logic          pkt_fwd, pkt_drop;

    input_p4_demux_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();
    input_p4_demux_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if [5] ();

    assign s_if.tdata  = in_data;
    assign s_if.tkeep  = in_keep;
    assign s_if.tuser  = in_user;
    assign s_if.tvalid = in_valid;
    assign s_if.tlast  = in_last;

    for (genvar k = 0; k < 5; k++) begin : g_port
        assign m_if[k].tready = rdy[k];
        assign o_valid[k] = m_if[k].tvalid;
        assign o_last[k]  = m_if[k].tlast;
        assign o_data[k]  = m_if[k].tdata;
        assign o_keep[k]  = m_if[k].tkeep;
        assign o_user[k]  = m_if[k].tuser;
    end

    input_p4_demux dut (
        .axis_aclk (clk),
        .axis_reset(rst),
        .s_axis    (s_if),
        .m_axis_0  (m_if[0]),
        .m_axis_1  (m_if[1]),
        .m_axis_2  (m_if[2]),
        .m_axis_3  (m_if[3]),
        .m_axis_4  (m_if[4]),
        .pkt_fwd   (pkt_fwd),
        .pkt_drop  (pkt_drop)
    );

    // Model: every forwarded beat, in order, with its switch; head is what
    // the outputs must present. mstate: 0 between packets, 1 forwarding, 2 dropping.
    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
        int            dest;
    } beat_t;
    beat_t fifo [$];
    int    mstate, mdest;
    logic  exp_fwd, exp_drop;
    int    n_vec, n_miss, obs_fwd, obs_drop;
    int    rdy_pct;
    int    hold_low [5];

    task automatic chk(input string nm, input logic [UW-1:0] got, input logic [UW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [319:0] rand_wide();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // Destination from the frame bytes: -1 means drop.
    function automatic int decode(input logic [DW-1:0] d);
        int et, vid;
        et  = int'(d[12*8 +: 8]) * 256 + int'(d[13*8 +: 8]);
        vid = (int'(d[14*8 +: 8]) % 16) * 256 + int'(d[15*8 +: 8]);
        if (et != 32'h8100) return 0;
        if (vid - 1 >= 0 && vid - 1 < 5) return vid - 1;
        return -1;
    endfunction

    function automatic logic [DW-1:0] mk_first(input int et, input int vid);
        logic [319:0] r;
        logic [DW-1:0] d;
        r = rand_wide();
        d = r[DW-1:0];
        d[12*8 +: 8] = 8'(et >> 8);
        d[13*8 +: 8] = 8'(et);
        d[14*8 +: 8] = {4'($urandom_range(0, 15)), 4'(vid >> 8)};
        d[15*8 +: 8] = 8'(vid);
        return d;
    endfunction

    // One clock: check tready, advance the model across the edge, check outputs.
    task automatic step(output logic acc);
        logic exp_rdy, pop, ev;
        int   hd, d;
        beat_t b;
        for (int k = 0; k < 5; k++) begin
            if (hold_low[k] > 0) begin
                rdy[k] = 1'b0;
                hold_low[k]--;
            end else begin
                rdy[k] = ($urandom_range(0, 99) < rdy_pct);
            end
        end
        #1;
        hd      = (fifo.size() > 0) ? fifo[0].dest : -1;
        exp_rdy = (mstate == 2) || (hd < 0) || rdy[hd];
        chk("s_tready", s_if.tready, exp_rdy);
        acc = in_valid && exp_rdy && !rst;
        pop = (hd >= 0) && rdy[hd];
        @(posedge clk);
        exp_fwd  = 1'b0;
        exp_drop = 1'b0;
        if (rst) begin
            fifo.delete();
            mstate = 0;
        end else begin
            if (pop) void'(fifo.pop_front());
            if (acc) begin
                b.d = in_data; b.k = in_keep; b.u = in_user; b.l = in_last;
                if (mstate == 0) begin
                    d = decode(in_data);
                    if (d >= 0) begin
                        b.dest = d; fifo.push_back(b);
                        exp_fwd = 1'b1; mdest = d;
                        mstate = in_last ? 0 : 1;
                    end else begin
                        exp_drop = 1'b1;
                        mstate = in_last ? 0 : 2;
                    end
                end else if (mstate == 1) begin
                    b.dest = mdest; fifo.push_back(b);
                    if (in_last) mstate = 0;
                end else if (in_last) begin
                    mstate = 0;
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            ev = (fifo.size() > 0) && (fifo[0].dest == k);
            chk($sformatf("tvalid%0d", k), o_valid[k], ev);
        end
        if (fifo.size() > 0) begin
            hd = fifo[0].dest;
            chk($sformatf("tdata%0d", hd), o_data[hd], fifo[0].d);
            chk($sformatf("tkeep%0d", hd), o_keep[hd], fifo[0].k);
            chk($sformatf("tuser%0d", hd), o_user[hd], fifo[0].u);
            chk($sformatf("tlast%0d", hd), o_last[hd], fifo[0].l);
        end
        chk("pkt_fwd", pkt_fwd, exp_fwd);
        chk("pkt_drop", pkt_drop, exp_drop);
        if (pkt_fwd === 1'b1) obs_fwd++;
        if (pkt_drop === 1'b1) obs_drop++;
    endtask

    task automatic idle(input int n);
        logic acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    // Offer a packet; hold_at stalls switch 4 for 5 cycles, abort_at resets mid-packet.
    task automatic send_pkt(input int et, input int vid, input int nb, input int vpct,
                            input int hold_at, input int abort_at);
        logic [319:0] r;
        logic acc;
        int guard;
        for (int b = 0; b < nb; b++) begin
            r       = rand_wide();
            in_data = (b == 0) ? mk_first(et, vid) : r[DW-1:0];
            r       = rand_wide();
            in_user = r[UW-1:0];
            in_keep = $urandom();
            in_last = (b == nb - 1);
            if (b == hold_at) hold_low[4] = 5;
            if (b == abort_at) begin
                rst = 1'b1;
                in_valid = 1'b1;
                step(acc);
                rst = 1'b0;
                in_valid = 1'b0;
                chk("rst_valids", o_valid, 5'd0);
                return;
            end
            in_valid = 1'b0;
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                if (!in_valid) in_valid = ($urandom_range(0, 99) < vpct);
                step(acc);
                guard++;
            end
            if (!acc) begin
                n_vec++; n_miss++;
                $display("FAIL accept_timeout: beat %0d not accepted within %0d cycles", b, guard);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_miss = 0; obs_fwd = 0; obs_drop = 0;
        mstate = 0; mdest = 0; exp_fwd = 1'b0; exp_drop = 1'b0;
        rdy_pct = 100;
        for (int k = 0; k < 5; k++) hold_low[k] = 0;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; in_keep = '0; in_user = '0; rdy = 5'h1F;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_tready", s_if.tready, 1'b1);
        chk("reset_tvalid", o_valid, 5'd0);
        chk("reset_fwd", pkt_fwd, 1'b0);
        chk("reset_drop", pkt_drop, 1'b0);

        chk("model_vid3", decode(mk_first(32'h8100, 3)), 2);
        chk("model_untag", decode(mk_first(32'h0800, 7)), 0);
        chk("model_vid9", decode(mk_first(32'h8100, 9)), -1);
        chk("model_vid0", decode(mk_first(32'h8100, 0)), -1);
        chk("model_vid5", decode(mk_first(32'h8100, 5)), 4);

        send_pkt(32'h8100, 3, 3, 100, -1, -1);
        idle(2);
        chk("t1_fwd_count", obs_fwd, 1);

        send_pkt(32'h0800, 0, 2, 100, -1, -1);
        idle(2);

        obs_fwd = 0; obs_drop = 0;
        send_pkt(32'h8100, 9, 4, 100, -1, -1);
        send_pkt(32'h8100, 1, 2, 100, -1, -1);
        idle(2);
        chk("t3_drop_count", obs_drop, 1);
        chk("t3_fwd_count", obs_fwd, 1);

        send_pkt(32'h8100, 5, 4, 100, 1, -1);
        idle(2);

        obs_fwd = 0;
        for (int v = 1; v <= 5; v++) send_pkt(32'h8100, v, 1, 100, -1, -1);
        idle(2);
        chk("t5_fwd_count", obs_fwd, 5);

        send_pkt(32'h8100, 2, 4, 100, -1, 1);
        send_pkt(32'h8100, 4, 2, 100, -1, -1);
        idle(2);

        rdy_pct = 70;
        for (int p = 0; p < 300; p++) begin
            int et, vid, sel;
            sel = $urandom_range(0, 9);
            et  = (sel < 7) ? 32'h8100 : ((sel == 7) ? 32'h0800 : 32'h86DD);
            vid = ($urandom_range(0, 15) == 0) ? 4095 : $urandom_range(0, 8);
            send_pkt(et, vid, $urandom_range(1, 4), 80, -1, -1);
        end
        rdy_pct = 100;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
